// File: rtl/ror_unit_if.sv
// Request/response bundle for the multi-cycle rotate-right engine.
// Master drives the request side; slave returns status and result.
interface ror_unit_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
);
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic [AW-1:0]    amount;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start,
    output data_in,
    output amount,
    input  busy,
    input  done,
    input  result
  );

  modport slave (
    input  start,
    input  data_in,
    input  amount,
    output busy,
    output done,
    output result
  );
endinterface

// File: rtl/ror_unit.sv
// Multi-cycle rotate-right engine, up to STEP bits per clock.
// Result register doubles as the working register during rotation.
module ror_unit #(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  parameter int AW    = 5
) (
  input  logic       clk,
  input  logic       Clear,
  ror_unit_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ROT  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [AW:0] STEP_V = (AW+1)'(STEP);

  logic [1:0]       state;
  logic [1:0]       state_nx;
  logic [WIDTH-1:0] res_q;
  logic [AW-1:0]    rem_q;
  logic             busy_q;
  logic             done_q;

  logic             accept;
  logic             big;
  logic             last;
  logic [AW-1:0]    step_amt;
  logic [WIDTH-1:0] rot_val;

  // Chunk size this cycle: STEP while more than STEP remains, else the rest.
  always_comb begin
    big      = {1'b0, rem_q} > STEP_V;
    last     = !big;
    step_amt = big ? STEP_V[AW-1:0] : rem_q;
  end

  // Rotate the working register right by the current chunk.
  always_comb begin
    rot_val = (res_q >> step_amt)
            | (res_q << (WIDTH - int'(step_amt)));
  end

  // Next-state decode; start only counts while idle.
  always_comb begin
    accept   = 1'b0;
    state_nx = state;
    unique case (1'b1)
      (state == S_IDLE): begin
        accept = bus.start;
        if (bus.start)
          state_nx = (bus.amount != '0) ? S_ROT : S_DONE;
      end
      (state == S_ROT): begin
        if (last)
          state_nx = S_DONE;
      end
      (state == S_DONE): begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // State register plus registered status flags.
  always_ff @(posedge clk or negedge Clear) begin
    if (!Clear) begin
      state  <= S_IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      busy_q <= (state_nx != S_IDLE);
      done_q <= (state_nx == S_DONE);
    end
  end

  // Operand capture on accept, then chunked rotation.
  always_ff @(posedge clk or negedge Clear) begin
    if (!Clear) begin
      res_q <= '0;
      rem_q <= '0;
    end else if (accept) begin
      res_q <= bus.data_in;
      rem_q <= bus.amount;
    end else if (state == S_ROT) begin
      res_q <= rot_val;
      rem_q <= rem_q - step_amt;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = res_q;

endmodule

// File: tb/tb_ror_unit.sv
// Directed bench for ror_unit.
// Hand-computed rotate results and done latencies.
module tb_ror_unit;

  logic clk;
  logic Clear;
  int   total;
  int   bad;
  int   done_cnt;

  ror_unit_if #(.WIDTH(32), .AW(5)) bus ();

  ror_unit #(.WIDTH(32), .STEP(4), .AW(5)) dut (
    .clk   (clk),
    .Clear (Clear),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (bus.done === 1'b1) done_cnt++;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, wait for done, check latency and result.
  task automatic run_op(input string tag,
                        input logic [31:0] d,
                        input logic [4:0] a,
                        input int n_exp,
                        input logic [31:0] r_exp);
    int n;
    int c0;
    bus.start   = 1'b1;
    bus.data_in = d;
    bus.amount  = a;
    tick();
    bus.start   = 1'b0;
    bus.data_in = 32'h5A5A_A5A5;
    bus.amount  = 5'd7;
    n = 0;
    while (bus.done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk({tag, " lat"}, n, n_exp);
    chk({tag, " res"}, bus.result, r_exp);
    chk({tag, " busy@done"}, {31'd0, bus.busy}, 32'd1);
    c0 = done_cnt;
    tick();
    chk({tag, " done1cyc"}, {31'd0, bus.done}, 32'd0);
    chk({tag, " idle"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, " hold"}, bus.result, r_exp);
    chk({tag, " pulses"}, done_cnt - c0, 1);
  endtask

  initial begin
    int c0;
    total       = 0;
    bad         = 0;
    done_cnt    = 0;
    Clear       = 1'b0;
    bus.start   = 1'b0;
    bus.data_in = '0;
    bus.amount  = '0;
    #12;
    chk("rst busy", {31'd0, bus.busy}, 32'd0);
    chk("rst done", {31'd0, bus.done}, 32'd0);
    chk("rst res", bus.result, 32'd0);
    #5;
    Clear = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle busy", {31'd0, bus.busy}, 32'd0);
      chk("idle done", {31'd0, bus.done}, 32'd0);
      chk("idle res", bus.result, 32'd0);
    end

    run_op("ror5", 32'h0000_03C0, 5'd5, 2, 32'h0000_001E);
    run_op("ror1", 32'h0000_0001, 5'd1, 1, 32'h8000_0000);
    run_op("ror31", 32'h8000_0001, 5'd31, 8, 32'h0000_0003);
    run_op("ror0", 32'hDEAD_BEEF, 5'd0, 0, 32'hDEAD_BEEF);
    run_op("ror4", 32'h1234_5678, 5'd4, 1, 32'h8123_4567);
    run_op("ror12", 32'hF000_000F, 5'd12, 3, 32'h00FF_0000);

    // Second request during ROTATE and during DONE must be dropped.
    c0 = done_cnt;
    bus.start   = 1'b1;
    bus.data_in = 32'h0000_F000;
    bus.amount  = 5'd8;
    tick();
    bus.data_in = 32'hFFFF_FFFF;
    bus.amount  = 5'd3;
    tick();
    chk("ign rot busy", {31'd0, bus.busy}, 32'd1);
    bus.start = 1'b0;
    tick();
    chk("ign done", {31'd0, bus.done}, 32'd1);
    chk("ign res", bus.result, 32'h0000_00F0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("ign idle", {31'd0, bus.busy}, 32'd0);
    for (int i = 0; i < 4; i++) tick();
    chk("ign busy", {31'd0, bus.busy}, 32'd0);
    chk("ign hold", bus.result, 32'h0000_00F0);
    chk("ign pulses", done_cnt - c0, 1);

    // Asynchronous clear mid-rotation abandons the operation.
    c0 = done_cnt;
    bus.start   = 1'b1;
    bus.data_in = 32'h1234_5678;
    bus.amount  = 5'd16;
    tick();
    bus.start = 1'b0;
    tick();
    chk("clr pre busy", {31'd0, bus.busy}, 32'd1);
    #2;
    Clear = 1'b0;
    #1;
    chk("clr busy", {31'd0, bus.busy}, 32'd0);
    chk("clr done", {31'd0, bus.done}, 32'd0);
    chk("clr res", bus.result, 32'd0);
    tick();
    tick();
    #2;
    Clear = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("clr nodone", done_cnt - c0, 0);
    chk("clr idle", {31'd0, bus.busy}, 32'd0);
    run_op("post", 32'h0000_0010, 5'd4, 1, 32'h0000_0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
